// File: rtl/axis_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_pkg
// Brief    : Shared defaults and packet-FSM state encoding for axis_pkt_tx.
// Revision : 1.0
// ============================================================================
package axis_pkt_pkg;

    localparam int C_DATA_W     = 32;
    localparam int C_FIFO_DEPTH = 16;
    localparam int C_LEN_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } pkt_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_pkt_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock show-ahead FIFO with count-based full/empty flags.
// Revision : 1.0
// ============================================================================
module sync_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int DEPTH  = C_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_wr_drop
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                w_wr;
    logic                w_rd;

    assign o_full    = (r_count == (c_ADDR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_wr_drop = i_wr_en && o_full;
    assign w_wr      = i_wr_en && !o_full;
    // A read on an empty buffer is ignored, so a same-cycle write just lands.
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_tx
// Brief    : Buffers producer words and emits fixed-length AXI-Stream packets.
// Revision : 1.0
// ============================================================================
module axis_pkt_tx
    import axis_pkt_pkg::*;
#(
    parameter int DATA_W     = C_DATA_W,
    parameter int FIFO_DEPTH = C_FIFO_DEPTH,
    parameter int LEN_W      = C_LEN_W
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_full,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              m_axis_valid,
    output logic              m_axis_last,
    input  logic              m_axis_ready,
    output logic              o_ovf,
    output logic              o_intr
);

    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_empty;
    logic              w_drop;
    logic              w_load;
    logic              w_hs;
    logic              w_beat_last;

    pkt_state_t        r_state;
    pkt_state_t        w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_cnt_nxt;

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_ovf;
    logic              r_intr;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (axi_clk),
        .rst_n     (axi_rst),
        .i_wr_en   (i_data_valid),
        .i_wr_data (i_data),
        .i_rd_en   (w_load),
        .o_rd_data (w_fifo_data),
        .o_full    (o_full),
        .o_empty   (w_fifo_empty),
        .o_wr_drop (w_drop)
    );

    assign w_hs   = r_valid && m_axis_ready;
    assign w_load = !w_fifo_empty && (!r_valid || m_axis_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_beat_last = 1'b0;
        case (r_state)
            ST_IDLE, ST_DRAIN: begin
                if (r_state == ST_DRAIN && w_hs) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
                // In DRAIN a load implies the last beat is leaving, so the
                // next packet may open in the same cycle.
                if (w_load) begin
                    w_len_nxt   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
                    w_cnt_nxt   = LEN_W'(1);
                    w_beat_last = (w_len_nxt == LEN_W'(1));
                    w_state_nxt = w_beat_last ? ST_DRAIN : ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_load) begin
                    w_beat_last = (r_cnt == r_len - LEN_W'(1));
                    w_cnt_nxt   = r_cnt + LEN_W'(1);
                    if (w_beat_last) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= w_fifo_data;
                r_valid <= 1'b1;
                r_last  <= w_beat_last;
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
            r_ovf  <= r_ovf | w_drop;
            r_intr <= w_hs && r_last;
        end
    end

    assign m_axis_data  = r_data;
    assign m_axis_valid = r_valid;
    assign m_axis_last  = r_last;
    assign o_ovf        = r_ovf;
    assign o_intr       = r_intr;

endmodule
`default_nettype wire
